// File: rtl/alu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : alu_seq_if                                                    |
// | Description: Operand/result handshake bundle for the sequential ALU.       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      ctrl;
    logic [XLEN-1:0] din_0;
    logic [XLEN-1:0] din_1;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, ctrl, din_0, din_1, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, ctrl, din_0, din_1, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : alu_seq                                                       |
// | Description: Handshaked RV32/RV64 ALU; base ops in one cycle, M-extension  |
// |              mul/div/rem by iterative shift-add / restoring division.      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module alu_seq #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input wire         clk,
    input wire         reset,
    alu_seq_if.slave   bus
);

    localparam int c_SHW = $clog2(XLEN);
    localparam int c_CW  = $clog2(XLEN + 2);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_m;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;

    logic              w_m;
    logic              w_alt;
    logic [2:0]        w_f3;
    logic [c_SHW-1:0]  w_shamt;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_take_m;
    logic [XLEN-1:0]   w_sra;
    logic [XLEN-1:0]   w_base;

    logic              w_sa;
    logic              w_sb;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_sh;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_div_res;

    assign w_m        = bus.ctrl[4];
    assign w_alt      = bus.ctrl[3];
    assign w_f3       = bus.ctrl[2:0];
    assign w_shamt    = bus.din_1[c_SHW-1:0];
    assign w_in_ready = (r_state == c_ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_take_m   = w_m && (ENABLE_M != 0);
    assign w_sra      = $signed(bus.din_0) >>> w_shamt;

    always_comb begin
        w_base = '0;
        case (w_f3)
            3'b000:  w_base = w_alt ? (bus.din_0 - bus.din_1) : (bus.din_0 + bus.din_1);
            3'b001:  w_base = bus.din_0 << w_shamt;
            3'b010:  w_base = {{(XLEN-1){1'b0}}, ($signed(bus.din_0) < $signed(bus.din_1))};
            3'b011:  w_base = {{(XLEN-1){1'b0}}, (bus.din_0 < bus.din_1)};
            3'b100:  w_base = bus.din_0 ^ bus.din_1;
            3'b101:  w_base = w_alt ? w_sra : (bus.din_0 >> w_shamt);
            3'b110:  w_base = bus.din_0 | bus.din_1;
            default: w_base = bus.din_0 & bus.din_1;
        endcase
    end

    // Operand signedness: MULH both, MULHSU rs1 only, DIV/REM both.
    assign w_sa    = (r_state == c_ST_MUL) ? ((r_op == 3'b001) || (r_op == 3'b010)) : !r_op[0];
    assign w_sb    = (r_state == c_ST_MUL) ? (r_op == 3'b001) : !r_op[0];
    assign w_a_neg = w_sa && r_a[XLEN-1];
    assign w_b_neg = w_sb && r_b[XLEN-1];
    assign w_a_abs = w_a_neg ? -r_a : r_a;
    assign w_b_abs = w_b_neg ? -r_b : r_b;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
    assign w_div_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_m};
    assign w_div_sub = w_div_sh[XLEN-1:0] - r_m;

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_mul_res  = (r_op[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

    // Divide-by-zero bypasses sign correction; min/-1 falls out of the unsigned path naturally.
    assign w_quo     = (r_b == '0) ? '1  : (r_neg_q ? -r_lo : r_lo);
    assign w_rem     = (r_b == '0) ? r_a : (r_neg_r ? -r_hi : r_hi);
    assign w_div_res = r_op[1] ? w_rem : w_quo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && w_take_m) begin
                    w_state_nxt = w_f3[2] ? c_ST_DIV : c_ST_MUL;
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_m         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_take_m) begin
                            r_op  <= w_f3;
                            r_a   <= bus.din_0;
                            r_b   <= bus.din_1;
                            r_cnt <= '0;
                        end else begin
                            r_result    <= w_m ? '0 : w_base;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                c_ST_MUL, c_ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '0) begin
                        // Multiplication commutes, so both ops share the same operand slots.
                        r_m     <= w_b_abs;
                        r_lo    <= w_a_abs;
                        r_hi    <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end else if (r_cnt == c_LAST) begin
                        r_result    <= (r_state == c_ST_MUL) ? w_mul_res : w_div_res;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else if (r_state == c_ST_MUL) begin
                        r_hi <= w_mul_sum[XLEN:1];
                        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end else begin
                        r_hi <= w_div_ge ? w_div_sub : w_div_sh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_alu_seq                                                    |
// | Description: Self-checking bench for alu_seq against an arithmetic model.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

    localparam int XLEN = 32;

    localparam logic [4:0] c_ADD    = 5'b00000;
    localparam logic [4:0] c_SUB    = 5'b01000;
    localparam logic [4:0] c_SLT    = 5'b00010;
    localparam logic [4:0] c_SLTU   = 5'b00011;
    localparam logic [4:0] c_XOR    = 5'b00100;
    localparam logic [4:0] c_SRL    = 5'b00101;
    localparam logic [4:0] c_SRA    = 5'b01101;
    localparam logic [4:0] c_MUL    = 5'b10000;
    localparam logic [4:0] c_MULH   = 5'b10001;
    localparam logic [4:0] c_MULHSU = 5'b10010;
    localparam logic [4:0] c_MULHU  = 5'b10011;
    localparam logic [4:0] c_DIV    = 5'b10100;
    localparam logic [4:0] c_DIVU   = 5'b10101;
    localparam logic [4:0] c_REM    = 5'b10110;
    localparam logic [4:0] c_REMU   = 5'b10111;
    localparam int         c_MLAT   = XLEN + 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    alu_seq_if #(.XLEN(XLEN)) bus ();

    alu_seq #(.XLEN(XLEN), .ENABLE_M(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0] ea, eb, za, zb, p;
        logic [31:0] t;
        sa = a;
        sb = b;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        za = {32'd0, a};
        zb = {32'd0, b};
        if (!c[4]) begin
            case (c[2:0])
                3'd0: return c[3] ? a - b : a + b;
                3'd1: return a << b[4:0];
                3'd2: return {31'd0, sa < sb};
                3'd3: return {31'd0, a < b};
                3'd4: return a ^ b;
                3'd5: begin
                    if (c[3]) begin
                        t = sa >>> b[4:0];
                        return t;
                    end
                    return a >> b[4:0];
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
        case (c[2:0])
            3'd0: begin p = za * zb; return p[31:0];  end
            3'd1: begin p = ea * eb; return p[63:32]; end
            3'd2: begin p = ea * zb; return p[63:32]; end
            3'd3: begin p = za * zb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                t = sa / sb;
                return t;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                t = sa % sb;
                return t;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: expectation queued at accept, popped when the consumer takes a result.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", bus.out_valid, 1'b0);
                else                   check("result", bus.result, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_alu(bus.ctrl, bus.din_0, bus.din_1));
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.ctrl     = c;
        bus.din_0    = a;
        bus.din_1    = b;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din_0    = $urandom;
        bus.din_1    = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat      = 0;
        logic saw_rdy  = 1'b0;
        logic all_busy = 1'b1;
        issue(c, a, b);
        while (!bus.out_valid && lat < 100) begin
            saw_rdy  |= bus.in_ready;
            all_busy &= bus.busy;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check(tag, bus.result, exp);
        if (exp_lat > 0) begin
            check({tag, "_rdy"}, saw_rdy, 1'b0);
            check({tag, "_busy"}, all_busy, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_a, exp_b, pa, pb;
        logic        v_ok, r_ok, rdy_ok, saw_out;
        int          n;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.ctrl      = '0;
        bus.din_0     = '0;
        bus.din_1     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("add_wrap", c_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0);
        run_op("sub_wrap", c_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.ctrl     = 5'($urandom_range(0, 15));
            bus.din_0    = pick();
            bus.din_1    = pick();
            @(negedge clk);
            check("b2b_ready", bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
            check("b2b_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0;

        run_op("sra", c_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        run_op("srl", c_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 0);
        run_op("slt", c_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run_op("sltu", c_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);

        run_op("mul", c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, c_MLAT);
        run_op("mulhu", c_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, c_MLAT);
        run_op("mulh", c_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, c_MLAT);
        run_op("mulhsu", c_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_MLAT);

        run_op("div_neg", c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, c_MLAT);
        run_op("rem_neg", c_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, c_MLAT);
        run_op("divu_z", c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, c_MLAT);
        run_op("remu_z", c_REMU, 32'd5, 32'd0, 32'd5, c_MLAT);
        run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, c_MLAT);
        run_op("rem_ovf", c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, c_MLAT);

        // Backpressure: hold a result for 10 cycles while a new op waits.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        pa    = $urandom;
        pb    = $urandom;
        exp_a = pa ^ pb;
        issue(c_XOR, pa, pb);
        pa    = $urandom;
        pb    = $urandom;
        exp_b = pa + pb;
        bus.in_valid = 1'b1;
        bus.ctrl     = c_ADD;
        bus.din_0    = pa;
        bus.din_1    = pb;
        v_ok   = 1'b1;
        r_ok   = 1'b1;
        rdy_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            v_ok   &= bus.out_valid;
            r_ok   &= (bus.result == exp_a);
            rdy_ok &= !bus.in_ready;
        end
        check("bp_valid_held", v_ok, 1'b1);
        check("bp_result_held", r_ok, 1'b1);
        check("bp_not_ready", rdy_ok, 1'b1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_new_valid", bus.out_valid, 1'b1);
        check("bp_new_result", bus.result, exp_b);
        @(posedge clk);
        #1;

        // Reset lands on the 10th iteration of a DIV.
        issue(c_DIV, $urandom, $urandom | 32'd1);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_result", bus.result, 32'd0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_ready", bus.in_ready, 1'b1);
        saw_out = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            saw_out |= bus.out_valid;
        end
        check("abort_no_output", saw_out, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.ctrl      = 5'($urandom);
            bus.din_0     = pick();
            bus.din_1     = pick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
